block_dispatcher: RTL

Kernel-level dispatcher that splits a launch of thread_count threads into blocks of THREADS_PER_BLOCK and hands them to NUM_CORES compute cores. It drives each core's start/reset/block-id/thread-count inputs and consumes each core's done. It sits between device control registers and the cores, and is the initiator side of the per-core start/done handshake. It asserts kernel done once every block has completed.

---
 rtl/block_dispatcher.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel launch into blocks and dispatches them to compute cores.
// Optional DISPATCH_CYCLE_COUNT_EN adds a saturating kernel_cycles counter output.
module block_dispatcher #(
    parameter int NUM_CORES = 2,
    parameter int THREADS_PER_BLOCK = 4,
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               thread_count,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [NUM_CORES-1:0]     core_reset,
    output logic [NUM_CORES*8-1:0]   core_block_id,
    output logic [NUM_CORES*TCW-1:0] core_thread_count,
    input  logic [NUM_CORES-1:0]     core_done,
`ifdef DISPATCH_CYCLE_COUNT_EN
    output logic [15:0]              kernel_cycles,
`endif
    output logic                     done
);
    localparam int SH = $clog2(THREADS_PER_BLOCK);
    localparam logic [15:0] TPB16 = 16'(THREADS_PER_BLOCK);

    typedef enum logic [1:0] {K_IDLE, K_INIT, K_RUN, K_DONE} kst_t;
    typedef enum logic [1:0] {C_FREE, C_BUSY, C_REL} cst_t;

    kst_t                     kst_q, kst_d;
    cst_t                     cst_q [NUM_CORES];
    cst_t                     cst_d [NUM_CORES];
    logic [7:0]               tc_q, tc_d;
    logic [8:0]               total_q, total_d;
    logic [8:0]               disp_q, disp_d;
    logic [8:0]               bdone_q, bdone_d;
    logic                     done_q, done_d;
    logic [NUM_CORES-1:0]     core_start_q, core_start_d;
    logic [NUM_CORES-1:0]     core_reset_q, core_reset_d;
    logic [NUM_CORES*8-1:0]   block_id_q, block_id_d;
    logic [NUM_CORES*TCW-1:0] tcount_q, tcount_d;
    logic [15:0]              rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            kst_q        <= K_IDLE;
            cst_q        <= '{default: C_FREE};
            tc_q         <= '0;
            total_q      <= '0;
            disp_q       <= '0;
            bdone_q      <= '0;
            done_q       <= 1'b0;
            core_start_q <= '0;
            core_reset_q <= '1;
            block_id_q   <= '0;
            tcount_q     <= '0;
        end else begin
            kst_q        <= kst_d;
            cst_q        <= cst_d;
            tc_q         <= tc_d;
            total_q      <= total_d;
            disp_q       <= disp_d;
            bdone_q      <= bdone_d;
            done_q       <= done_d;
            core_start_q <= core_start_d;
            core_reset_q <= core_reset_d;
            block_id_q   <= block_id_d;
            tcount_q     <= tcount_d;
        end
    end

    always_comb begin
        kst_d = kst_q;
        case (kst_q)
            K_IDLE:  kst_d = start ? K_INIT : K_IDLE;
            K_INIT:  kst_d = K_RUN;
            K_RUN:   kst_d = (bdone_q == total_q) ? K_DONE : K_RUN;
            K_DONE:  kst_d = start ? K_DONE : K_IDLE;
            default: kst_d = K_IDLE;
        endcase
    end

    always_comb begin
        tc_d         = tc_q;
        total_d      = total_q;
        disp_d       = disp_q;
        bdone_d      = bdone_q;
        done_d       = done_q;
        core_start_d = core_start_q;
        core_reset_d = core_reset_q;
        block_id_d   = block_id_q;
        tcount_d     = tcount_q;
        cst_d        = cst_q;
        rem          = '0;
        // Cores are scanned in ascending order so lower-index free cores take the lower block ids.
        for (int i = 0; i < NUM_CORES; i++) begin
            if (cst_q[i] == C_BUSY && core_done[i]) begin
                core_start_d[i] = 1'b0;
                core_reset_d[i] = 1'b1;
                bdone_d         = bdone_d + 9'd1;
                cst_d[i]        = C_REL;
            end else if (cst_q[i] == C_REL) begin
                core_reset_d[i] = 1'b0;
                cst_d[i]        = C_FREE;
            end else if ((kst_q == K_INIT || kst_q == K_RUN) && cst_q[i] == C_FREE && disp_d < total_q) begin
                rem                        = 16'(tc_q) - 16'(disp_d) * TPB16;
                core_start_d[i]            = 1'b1;
                block_id_d[8*i +: 8]       = disp_d[7:0];
                tcount_d[TCW*i +: TCW]     = TCW'(rem > TPB16 ? TPB16 : rem);
                disp_d                     = disp_d + 9'd1;
                cst_d[i]                   = C_BUSY;
            end
        end
        case (kst_q)
            K_IDLE: begin
                core_reset_d = start ? '1 : '0;
                if (start) begin
                    tc_d    = thread_count;
                    total_d = (9'(thread_count) + 9'(THREADS_PER_BLOCK - 1)) >> SH;
                    disp_d  = '0;
                    bdone_d = '0;
                end
            end
            K_INIT: core_reset_d = '0;
            K_RUN:  done_d = (bdone_q == total_q);
            K_DONE: begin
                done_d       = start;
                core_start_d = start ? core_start_d : '0;
            end
            default: ;
        endcase
    end

`ifdef DISPATCH_CYCLE_COUNT_EN
    logic [15:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = (kst_q == K_IDLE && start) ? '0 :
                   ((kst_q == K_INIT || kst_q == K_RUN) && cycles_q != 16'hFFFF) ? cycles_q + 16'd1 :
                   cycles_q;
    end

    always_ff @(posedge clk) begin
        if (reset) cycles_q <= '0;
        else       cycles_q <= cycles_d;
    end

    assign kernel_cycles = cycles_q;
`endif

    assign core_start        = core_start_q;
    assign core_reset        = core_reset_q;
    assign core_block_id     = block_id_q;
    assign core_thread_count = tcount_q;
    assign done              = done_q;
endmodule
